// File: rtl/seq_addsub_pkg.sv
// Shared types and defaults for the chunk-serial adder/subtractor.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package seq_addsub_pkg;

   // Operation sequencer states: waiting for start, or stepping through chunks.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int WIDTH_DEF = 16;
   localparam int CHUNK_DEF = 4;

endpackage

// File: rtl/seq_addsub_chunk_add.sv
// Combinational CHUNK-bit adder slice, shared by every step of an operation.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the outputs follow the inputs.
//
// Ports:
//   x, y   : CHUNK-bit addends
//   ci     : carry into bit 0
//   sum    : CHUNK-bit sum
//   co     : carry out of the top bit
//   c_msb  : carry into the top bit (used for signed overflow)
module chunk_add #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] sum,
   output logic             co,
   output logic             c_msb
);

   logic [CHUNK:0] full;

   assign full  = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
   assign sum   = full[CHUNK-1:0];
   assign co    = full[CHUNK];
   // The top sum bit is x^y^carry_in at that bit, so the carry in can be recovered.
   assign c_msb = x[CHUNK-1] ^ y[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/seq_addsub.sv
// Sequential add/subtract, CHUNK bits per clock over WIDTH/CHUNK cycles.
// Latency: done rises NCH edges after the edge that samples start.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, sub     : request and mode (0 add, 1 subtract), sampled while idle
//   a, b, cin      : operands and carry/borrow-in, sampled with start
//   busy, done     : operation in progress, one-cycle publish pulse
//   s, cout, ovf   : published result, carry-out (1 = no borrow in sub), signed overflow
module seq_addsub
   import seq_addsub_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CHUNK = CHUNK_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCH - 1);

   if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("seq_addsub: WIDTH must be a multiple of CHUNK");
   end

   state_t           state;
   logic [WIDTH-1:0] work;     // holds A; sum chunks overwrite it in place
   logic [WIDTH-1:0] b_r;      // B, already inverted for subtraction
   logic             carry;
   logic [IW-1:0]    idx;

   logic [CHUNK-1:0] x_c, y_c, sum_c;
   logic             co_c, cmsb_c;
   logic [WIDTH-1:0] work_nxt;

   // Select the active chunk and splice its sum back into the work value.
   always_comb begin
      x_c      = '0;
      y_c      = '0;
      work_nxt = work;
      for (int i = 0; i < NCH; i++) begin
         if (idx == IW'(i)) begin
            x_c = work[i*CHUNK +: CHUNK];
            y_c = b_r[i*CHUNK +: CHUNK];
            work_nxt[i*CHUNK +: CHUNK] = sum_c;
         end
      end
   end

   chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
      .x     (x_c),
      .y     (y_c),
      .ci    (carry),
      .sum   (sum_c),
      .co    (co_c),
      .c_msb (cmsb_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         work  <= '0;
         b_r   <= '0;
         carry <= 1'b0;
         idx   <= '0;
         s     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  work  <= a;
                  // a - b - cin == a + ~b + (1 - cin)
                  b_r   <= sub ? ~b : b;
                  carry <= sub ? ~cin : cin;
                  idx   <= '0;
               end
            end
            RUN: begin
               work  <= work_nxt;
               carry <= co_c;
               idx   <= idx + 1'b1;
               if (idx == LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  s     <= work_nxt;
                  cout  <= co_c;
                  ovf   <= cmsb_c ^ co_c;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub (WIDTH=16, CHUNK=4): directed vectors push
// expected results with their due cycle; a monitor pops and compares on done.
module tb_seq_addsub;

   localparam int WIDTH = 16;
   localparam int CHUNK = 4;
   localparam int NCH   = WIDTH / CHUNK;

   typedef struct {
      logic [WIDTH-1:0] s;
      logic             cout;
      logic             ovf;
      int               due;
      string            tag;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   exp_t exp_q[$];
   int   cyc       = 0;
   int   n_vec     = 0;
   int   n_miss    = 0;
   logic prev_done = 1'b0;

   seq_addsub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .s     (s),
      .cout  (cout),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done) begin
         chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, "_s"},    {16'd0, s},     {16'd0, e.s});
            chk({e.tag, "_cout"}, {31'd0, cout},  {31'd0, e.cout});
            chk({e.tag, "_ovf"},  {31'd0, ovf},   {31'd0, e.ovf});
            chk({e.tag, "_cyc"},  cyc,            e.due);
         end
      end
      prev_done = done;
   end

   // Drive one request at the current negedge; start drops at the next negedge.
   task automatic issue(input string tag, input logic m, input logic [WIDTH-1:0] va,
                        input logic [WIDTH-1:0] vb, input logic vc,
                        input logic [WIDTH-1:0] es, input logic ec, input logic eo);
      exp_t e;
      e.s = es; e.cout = ec; e.ovf = eo; e.tag = tag;
      e.due = cyc + 1 + NCH;
      exp_q.push_back(e);
      sub = m; a = va; b = vb; cin = vc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = '0; b = '0; sub = 1'b0; cin = 1'b0;
   endtask

   // Step negedges until busy drops (that negedge is the done cycle).
   task automatic wait_idle(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   initial begin
      rst_n = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_s",    {16'd0, s},    32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      chk("rst_ovf",  {31'd0, ovf},  32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed arithmetic vectors.
      issue("add_basic", 1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      wait_idle("add_basic"); @(negedge clk);
      issue("add_ovf", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      wait_idle("add_ovf"); @(negedge clk);
      issue("add_wrap", 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
      wait_idle("add_wrap"); @(negedge clk);
      issue("sub_borrow", 1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      wait_idle("sub_borrow"); @(negedge clk);
      issue("sub_ovf", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      wait_idle("sub_ovf"); @(negedge clk);
      issue("sub_bin", 1'b1, 16'h1000, 16'h0001, 1'b1, 16'h0FFE, 1'b1, 1'b0);
      wait_idle("sub_bin"); @(negedge clk);

      // Start while busy is ignored; busy holds for the full NCH cycles.
      issue("ign_first", 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
      chk("ign_busy1", {31'd0, busy}, 32'd1);
      @(negedge clk);
      sub = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1; start = 1'b1;
      chk("ign_busy2", {31'd0, busy}, 32'd1);
      @(negedge clk);
      start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
      chk("ign_busy3", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("ign_busy4", {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk("ign_idle", {31'd0, busy}, 32'd0);
      repeat (8) @(negedge clk);

      // Back-to-back: second start in the done cycle, due 5 cycles later.
      issue("b2b_first", 1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
      wait_idle("b2b_first");
      chk("b2b_done_cycle", {31'd0, done}, 32'd1);
      issue("b2b_second", 1'b1, 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b1, 1'b0);
      wait_idle("b2b_second"); @(negedge clk);

      // Reset at idx=2 aborts without a done pulse.
      issue("abort", 1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("abort_busy_pre", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      void'(exp_q.pop_back());
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_s",    {16'd0, s},    32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      issue("post_rst", 1'b0, 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0);
      wait_idle("post_rst"); repeat (3) @(negedge clk);

      chk("queue_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/seq_addsub.md
SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 Parameter WIDTH, default 16, sets the operand and result width in bits; it SHALL be a multiple of CHUNK.
REQ-002 Parameter CHUNK, default 4, sets the bits added per clock; NCH = WIDTH/CHUNK cycles per operation.
REQ-003 Port clk, input, 1, is the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n, input, 1, is the reset: asynchronous, active-low.
REQ-005 Port start, input, 1, requests an operation; it SHALL be sampled only while busy=0.
REQ-006 Port sub, input, 1, selects the mode: 0 = add, 1 = subtract; it SHALL be sampled with start.
REQ-007 Ports a and b, input, WIDTH each, are the operands; they SHALL be sampled with start.
REQ-008 Port cin, input, 1, is carry-in (add) or borrow-in (sub); it SHALL be sampled with start.
REQ-009 Port busy, output, 1, SHALL be high while an operation is in progress.
REQ-010 Port done, output, 1, SHALL be a one-cycle pulse when a result is published.
REQ-011 Port s, output, WIDTH, is the result register.
REQ-012 Port cout, output, 1, is carry-out; in sub mode 1 means no borrow.
REQ-013 Port ovf, output, 1, is the two's-complement signed overflow flag.

Function
REQ-014 The FSM SHALL have two states, IDLE and RUN; busy SHALL be 1 exactly in RUN.
REQ-015 IDLE to RUN transition: start=1 at an edge in IDLE.
- Latch a into the A work register.
- Latch b into B, or ~b when sub=1.
- Set the carry register to cin (add) or ~cin (sub).
- Clear the chunk index to 0.
REQ-016 Each RUN cycle SHALL add chunk[idx] of A, B and the carry register, write the sum chunk into the work register, update carry, and increment idx.
REQ-017 On the cycle where idx = NCH-1 the FSM SHALL return to IDLE, and at that same edge:
- s gets the full work register.
- cout gets the final carry.
- ovf gets (carry into MSB) XOR (carry out of MSB).
- done goes high for exactly one cycle.
REQ-018 Latency: done SHALL be high NCH edges after the edge that sampled start.
REQ-019 s, cout and ovf SHALL hold their last published values during RUN and in IDLE until the next publication.
REQ-020 start while busy=1 SHALL be ignored: no effect on operands, mode or timing.
REQ-021 start in the cycle where done=1 SHALL be accepted, giving back-to-back operations with one result every NCH+1 cycles.
REQ-022 Results SHALL equal a+b+cin (add) or a-b-cin (sub), each modulo 2^WIDTH.
REQ-023 For CHUNK=WIDTH, NCH=1: done SHALL follow start by one edge, and the behaviour otherwise SHALL be as above.

Reset
REQ-024 While rst_n=0, the block SHALL hold the following regardless of clk:
- FSM in IDLE.
- busy=0, done=0.
- s=0, cout=0, ovf=0.
- Work registers, carry and idx cleared.
REQ-025 A reset during RUN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be handled normally.

Structure
REQ-026 Package seq_addsub_pkg SHALL hold the state typedef (IDLE, RUN) and the default WIDTH/CHUNK constants.
REQ-027 Sub-module chunk_add SHALL be a combinational CHUNK-bit adder.
- Inputs: x, y, ci.
- Outputs: sum, co, and c_msb (carry into the top bit).
- seq_addsub SHALL instantiate it once and reuse it every cycle.

Verification (WIDTH=16, CHUNK=4)
REQ-028 Add 0x1234+0x0FFF, cin=0 -> s=0x2233, cout=0, ovf=0; done 4 edges after start.
REQ-029 Add 0x7FFF+0x0001, cin=0 -> s=0x8000, cout=0, ovf=1. Add 0xFFFF+0x0000, cin=1 -> s=0x0000, cout=1, ovf=0.
REQ-030 Sub 0x0005-0x0007, cin=0 -> s=0xFFFE, cout=0, ovf=0. Sub 0x8000-0x0001, cin=0 -> s=0x7FFF, cout=1, ovf=1.
REQ-031 Start 0x0001+0x0001; assert start with 0xAAAA/0x5555 two cycles later -> s=0x0002; the second request is ignored and busy never drops early.
REQ-032 Re-assert start in the done cycle -> the second result is published exactly 5 cycles after the first done.
REQ-033 Drop rst_n at RUN idx=2 -> busy=0, s=0, and no done pulse; a fresh operation afterwards completes correctly.
